// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes a datapath memory op, runs a req/ack handshake with
// a variable-latency data memory and returns an aligned, extended load value.
module lsu_ctrl #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] dad,
  output logic [31:0] ddt,
  output logic [3:0]  be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] dad_q, dad_d;
  logic [31:0] ddt_q, ddt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flt_q, flt_d;

  logic        illegal, misalign;
  logic [3:0]  be_dec;
  logic [31:0] ddt_dec;
  logic [31:0] lane;
  logic [31:0] ld_val;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    case (funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default:                illegal = is_store & funct3[2];
    endcase
    misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
               ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_dec  = 4'b0001 << addr[1:0];
        ddt_dec = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_dec  = addr[1] ? 4'b1100 : 4'b0011;
        ddt_dec = {2{wdata[15:0]}};
      end
      default: begin
        be_dec  = 4'b1111;
        ddt_dec = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by the latched size.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   ld_val = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   ld_val = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
      default: ld_val = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dad_d   = dad_q;
    ddt_d   = ddt_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    off_d   = off_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal | misalign) begin
            flt_d   = 1'b1;
            state_d = RESP;
          end else begin
            dad_d   = {addr[31:2], 2'b00};
            be_d    = be_dec;
            ddt_d   = ddt_dec;
            we_d    = is_store;
            off_d   = addr[1:0];
            f3_d    = funct3;
            cnt_d   = '0;
            flt_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An ack in the final timeout cycle takes priority over the fault.
        if (mem_ack) begin
          if (!we_q) rdata_d = ld_val;
          flt_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            flt_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dad_q   <= '0;
      ddt_q   <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dad_q   <= dad_d;
      ddt_q   <= ddt_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
    end
  end

  assign mem_req = (state_q == REQ);
  assign mem_we  = we_q & mem_req;
  assign done    = (state_q == RESP);
  assign fault   = done & flt_q;
  assign stall   = rst & (((state_q == IDLE) & req_valid) | mem_req);
  assign rdata   = rdata_q;
  assign dad     = dad_q;
  assign ddt     = ddt_q;
  assign be      = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: fixed vector table, reset corner case and randomized ops
// compared against a byte-level reference model.
module tb_lsu_ctrl;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, fault, mem_we, mem_req;
  logic [31:0] rdata, dad, ddt;
  logic [3:0]  be;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rd;

  lsu_ctrl #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .fault(fault), .dad(dad), .ddt(ddt), .be(be),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack;
    int          e_done;
    int          e_req;
    logic        e_flt;
    logic [3:0]  e_be;
    logic [31:0] e_ddt;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one op; mem_ack is raised only in cycle ack_k (0 = never).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                        input int ack_k, output int done_k, output int req_n, output int stall_n,
                        output logic flt, output logic [31:0] dad_s, ddt_s,
                        output logic [3:0] be_s, output logic we_s);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = rd; mem_ack = 1'b0;
    done_k = -1; req_n = 0; stall_n = 0; flt = 1'b0;
    dad_s = '0; ddt_s = '0; be_s = '0; we_s = 1'b0;
    #1;
    if (stall) stall_n++;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      mem_ack = (k == ack_k);
      #1;
      if (stall) stall_n++;
      if (mem_req) begin
        if (req_n == 0) begin
          dad_s = dad; ddt_s = ddt; be_s = be; we_s = mem_we;
        end
        req_n++;
      end
      if (done) begin
        done_k = k;
        flt = fault;
        break;
      end
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic do_check(input string nm, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, wd, rd, input int ack_k,
                          input int e_done, e_req, input logic e_flt,
                          input logic [3:0] e_be, input logic [31:0] e_ddt, e_rdv);
    int dk, rn, sn;
    logic fl, ws;
    logic [31:0] ds, dts, rsamp;
    logic [3:0] bs;
    run_op(st, f3, a, wd, rd, ack_k, dk, rn, sn, fl, ds, dts, bs, ws);
    rsamp = rdata;
    check({nm, ".done_cycle"}, dk, e_done);
    check({nm, ".fault"}, {31'd0, fl}, {31'd0, e_flt});
    check({nm, ".req_cycles"}, rn, e_req);
    check({nm, ".stall_cycles"}, sn, e_done);
    check({nm, ".rdata"}, rsamp, e_rdv);
    if (e_req > 0) begin
      check({nm, ".dad"}, ds, a & 32'hFFFF_FFFC);
      check({nm, ".be"}, {28'd0, bs}, {28'd0, e_be});
      check({nm, ".ddt"}, dts, e_ddt);
      check({nm, ".mem_we"}, {31'd0, ws}, {31'd0, st});
    end
  endtask

  // Reference: size in bytes, lane masks and extension computed arithmetically.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                       input int ack_k, output int e_done, e_req, output logic e_flt,
                       output logic [3:0] e_be, output logic [31:0] e_ddt, output logic [31:0] e_val,
                       output logic e_load_ok);
    int n, off;
    logic sgn, legal;
    longint v;
    n = 1; sgn = 1'b1; legal = 1'b1;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; sgn = 1'b1; end
      3'd4: begin n = 1; sgn = 1'b0; legal = !st; end
      3'd5: begin n = 2; sgn = 1'b0; legal = !st; end
      default: legal = 1'b0;
    endcase
    off = int'(a[1:0]);
    e_be = '0; e_ddt = '0; e_val = '0; e_load_ok = 1'b0;
    if (!legal || (off % n) != 0) begin
      e_done = 1; e_req = 0; e_flt = 1'b1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (int'(i) >= off && int'(i) < off + n) e_be[i] = 1'b1;
        e_ddt = e_ddt | (((wd >> (8 * (int'(i) % n))) & 32'hFF) << (8 * i));
      end
      v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
      if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e_val = v[31:0];
      if (ack_k >= 1 && ack_k <= T) begin
        e_done = ack_k + 1; e_req = ack_k; e_flt = 1'b0;
        e_load_ok = !st;
      end else begin
        e_done = T + 1; e_req = T; e_flt = 1'b1;
      end
    end
  endtask

  task automatic rand_op(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, wd, rd, input int ack_k);
    int ed, er;
    logic ef, lok;
    logic [3:0] eb;
    logic [31:0] edt, ev;
    model(st, f3, a, wd, rd, ack_k, ed, er, ef, eb, edt, ev, lok);
    if (lok) exp_rd = ev;
    do_check(nm, st, f3, a, wd, rd, ack_k, ed, er, ef, eb, edt, exp_rd);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h100; wdata = 32'hFFFF_FFFF; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    exp_rd = '0;

    //                st    f3      addr         wdata         mem_rdata    ack done req flt be       ddt           rdata
    tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0,        3, 4,  3, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_1234, 1, 2,  1, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,         32'h80FF_1234, 2, 3,  2, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
    tbl[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,         32'h80FF_1234, 1, 2,  1, 1'b0, 4'b1100, 32'h0,         32'h0000_80FF};
    tbl[4]  = '{1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0,        2, 3,  2, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF};
    tbl[5]  = '{1'b1, 3'b000, 32'h101, 32'h0000_0055, 32'h0,        1, 2,  1, 1'b0, 4'b0010, 32'h5555_5555, 32'h0000_80FF};
    tbl[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h0,        1, 1,  0, 1'b1, 4'b0000, 32'h0,         32'h0000_80FF};
    tbl[7]  = '{1'b1, 3'b100, 32'h100, 32'h1,         32'h0,        1, 1,  0, 1'b1, 4'b0000, 32'h0,         32'h0000_80FF};
    tbl[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,         32'hAAAA_AAAA, 0, 16, 15, 1'b1, 4'b1111, 32'h0,        32'h0000_80FF};
    tbl[9]  = '{1'b0, 3'b001, 32'h106, 32'h0,         32'h8001_0000, 15, 16, 15, 1'b0, 4'b1100, 32'h0,       32'hFFFF_8001};
    tbl[10] = '{1'b0, 3'b011, 32'h100, 32'h0,         32'h0,        1, 1,  0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8001};
    tbl[11] = '{1'b0, 3'b000, 32'h100, 32'h0,         32'h0000_007F, 5, 6,  5, 1'b0, 4'b0001, 32'h0,         32'h0000_007F};
    tbl[12] = '{1'b0, 3'b010, 32'h200, 32'h0,         32'h1234_5678, 1, 2,  1, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
    tbl[13] = '{1'b0, 3'b101, 32'h101, 32'h0,         32'h0,        1, 1,  0, 1'b1, 4'b0000, 32'h0,         32'h1234_5678};

    #12;
    check("reset.stall", {31'd0, stall}, 32'd0);
    check("reset.mem_req", {31'd0, mem_req}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.fault", {31'd0, fault}, 32'd0);
    check("reset.mem_we", {31'd0, mem_we}, 32'd0);
    check("reset.rdata", rdata, 32'd0);
    check("reset.dad", dad, 32'd0);
    check("reset.ddt", ddt, 32'd0);
    check("reset.be", {28'd0, be}, 32'd0);
    req_valid = 1'b0; mem_ack = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();

    foreach (tbl[i]) begin
      do_check($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd,
               tbl[i].ack, tbl[i].e_done, tbl[i].e_req, tbl[i].e_flt, tbl[i].e_be,
               tbl[i].e_ddt, tbl[i].e_rd);
    end
    exp_rd = 32'h1234_5678;

    // Reset pulsed while a load waits for ack; a stray ack afterwards is ignored.
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; mem_ack = 1'b0;
    cycle();
    cycle();
    check("rstmid.req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid.mem_req", {31'd0, mem_req}, 32'd0);
    check("rstmid.stall", {31'd0, stall}, 32'd0);
    check("rstmid.done", {31'd0, done}, 32'd0);
    check("rstmid.rdata", rdata, 32'd0);
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    cycle();
    rst = 1'b1;
    cycle();
    check("lateack.done", {31'd0, done}, 32'd0);
    check("lateack.mem_req", {31'd0, mem_req}, 32'd0);
    check("lateack.rdata", rdata, 32'd0);
    mem_ack = 1'b0;
    exp_rd = '0;
    rand_op("postrst_lw", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BAD_CAFE, 1);

    for (int i = 0; i < 250; i++) begin
      logic [2:0] f3;
      int ak;
      f3 = 3'($urandom_range(0, 7));
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 6);
      rand_op($sformatf("rnd%0d", i), 1'($urandom), f3, $urandom, $urandom, $urandom, ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
